// File: rtl/median_window_ctrl.sv
// median_window_ctrl: pixel-stream front end for the 3x3 median filter.
// Tracks frame/line/column position from vsync/href, keeps the two previous
// lines in line buffers and presents a 3x3 window with replicated borders.
// Also flags lines whose length differs from H_ACT.
module median_window_ctrl #(
  parameter int H_ACT = 640,
  parameter int V_ACT = 480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_vsync,
  input  logic       pix_href,
  input  logic [7:0] pix_data,
  output logic [7:0] data11,
  output logic [7:0] data12,
  output logic [7:0] data13,
  output logic [7:0] data21,
  output logic [7:0] data22,
  output logic [7:0] data23,
  output logic [7:0] data31,
  output logic [7:0] data32,
  output logic [7:0] data33,
  output logic       win_vsync,
  output logic       win_href,
  output logic       line_len_err
);

  localparam int CW = $clog2(H_ACT + 1);
  localparam int AW = (H_ACT > 1) ? $clog2(H_ACT) : 1;
  localparam int RW = (V_ACT > 1) ? $clog2(V_ACT) : 1;
  localparam logic [CW-1:0] COL_END = CW'(H_ACT);
  localparam logic [RW-1:0] ROW_MAX = RW'(V_ACT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_LINE  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic            err_q, err_d;
  logic            win_vsync_q;
  logic            win_href_q, win_href_d;
  // Index 0 holds column c-2, index 2 holds column c.
  logic [2:0][7:0] top_q, mid_q, bot_q;
  logic [7:0]      lb1_q [H_ACT];
  logic [7:0]      lb2_q [H_ACT];

  logic            vs_rise_s;
  logic            accept_s;
  logic            in_line_s;
  logic [AW-1:0]   col_idx_s;
  logic [7:0]      rd_a_s, rd_b_s;
  logic [7:0]      new_top_s, new_mid_s, new_bot_s;

  // win_vsync_q is the previous vsync sample, so it doubles as the edge detector.
  assign vs_rise_s = pix_vsync & ~win_vsync_q;
  assign col_idx_s = col_q[AW-1:0];
  assign in_line_s = (col_q != COL_END);
  assign rd_a_s    = lb1_q[col_idx_s];
  assign rd_b_s    = lb2_q[col_idx_s];

  // Next-state logic: frame/line sequencing, counters and length checking.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    err_d      = err_q;
    accept_s   = 1'b0;
    win_href_d = pix_href & ~vs_rise_s & (state_q != ST_IDLE);
    if (vs_rise_s) begin
      // A new frame always wins, even over a pixel in the same cycle.
      state_d = ST_BLANK;
      row_d   = {RW{1'b0}};
      col_d   = {CW{1'b0}};
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_BLANK: begin
          if (pix_href) begin
            state_d  = ST_LINE;
            accept_s = 1'b1;
          end else begin
            state_d = ST_BLANK;
          end
        end
        ST_LINE: begin
          if (pix_href) begin
            accept_s = 1'b1;
          end else begin
            state_d = ST_BLANK;
            row_d   = (row_q == ROW_MAX) ? row_q : row_q + RW'(1);
            col_d   = {CW{1'b0}};
            // Short line: ended part way through; an empty count is not a line.
            if ((col_q != {CW{1'b0}}) && in_line_s) begin
              err_d = 1'b1;
            end else begin
              err_d = err_q;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
      if (accept_s) begin
        if (in_line_s) begin
          col_d = col_q + CW'(1);
        end else begin
          // Overlong line: column count parks at H_ACT.
          err_d = 1'b1;
        end
      end else begin
        err_d = err_d;
      end
    end
  end

  // Vertical border replication: choose the column values for rows r-2, r-1, r.
  always_comb begin
    new_bot_s = pix_data;
    if (row_q == {RW{1'b0}}) begin
      new_top_s = pix_data;
      new_mid_s = pix_data;
    end else if (row_q == RW'(1)) begin
      new_top_s = rd_a_s;
      new_mid_s = rd_a_s;
    end else begin
      new_top_s = rd_b_s;
      new_mid_s = rd_a_s;
    end
  end

  // Control state, counters and delayed sync outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      row_q       <= {RW{1'b0}};
      col_q       <= {CW{1'b0}};
      err_q       <= 1'b0;
      win_vsync_q <= 1'b0;
      win_href_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      err_q       <= err_d;
      win_vsync_q <= pix_vsync;
      win_href_q  <= win_href_d;
    end
  end

  // Horizontal taps: replicate at column 0, otherwise shift the new column in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_q <= 24'h00_0000;
      mid_q <= 24'h00_0000;
      bot_q <= 24'h00_0000;
    end else if (accept_s && in_line_s) begin
      if (col_q == {CW{1'b0}}) begin
        top_q <= {new_top_s, new_top_s, new_top_s};
        mid_q <= {new_mid_s, new_mid_s, new_mid_s};
        bot_q <= {new_bot_s, new_bot_s, new_bot_s};
      end else begin
        top_q <= {new_top_s, top_q[2], top_q[1]};
        mid_q <= {new_mid_s, mid_q[2], mid_q[1]};
        bot_q <= {new_bot_s, bot_q[2], bot_q[1]};
      end
    end else begin
      top_q <= top_q;
      mid_q <= mid_q;
      bot_q <= bot_q;
    end
  end

  // Line buffers: age row r-1 into r-2 and store the new pixel (read-before-write).
  always_ff @(posedge clk) begin
    if (accept_s && in_line_s) begin
      lb2_q[col_idx_s] <= rd_a_s;
      lb1_q[col_idx_s] <= pix_data;
    end
  end

  assign data11       = top_q[0];
  assign data12       = top_q[1];
  assign data13       = top_q[2];
  assign data21       = mid_q[0];
  assign data22       = mid_q[1];
  assign data23       = mid_q[2];
  assign data31       = bot_q[0];
  assign data32       = bot_q[1];
  assign data33       = bot_q[2];
  assign win_vsync    = win_vsync_q;
  assign win_href     = win_href_q;
  assign line_len_err = err_q;

endmodule

// File: tb/tb_median_window_ctrl.sv
// Testbench for median_window_ctrl with H_ACT=4, V_ACT=4.
// A frame-store model pushes the expected window for every accepted pixel;
// a monitor pops and compares whenever win_href is high. Directed checks
// with hand-computed constants cover reset, borders and error handling.
module tb_median_window_ctrl;

  localparam int H = 4;
  localparam int V = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pix_vsync = 1'b0;
  logic       pix_href = 1'b0;
  logic [7:0] pix_data = 8'h00;
  logic [7:0] data11, data12, data13, data21, data22, data23, data31, data32, data33;
  logic       win_vsync, win_href, line_len_err;
  logic [71:0] taps;

  int errors = 0;
  int checks = 0;
  logic [71:0] exp_q[$];
  logic [7:0]  img [0:V-1][0:H-1];
  int brow = 0;
  int bcol = 0;

  median_window_ctrl #(.H_ACT(H), .V_ACT(V)) dut (
    .clk(clk), .rst_n(rst_n),
    .pix_vsync(pix_vsync), .pix_href(pix_href), .pix_data(pix_data),
    .data11(data11), .data12(data12), .data13(data13),
    .data21(data21), .data22(data22), .data23(data23),
    .data31(data31), .data32(data32), .data33(data33),
    .win_vsync(win_vsync), .win_href(win_href), .line_len_err(line_len_err)
  );

  assign taps = {data11, data12, data13, data21, data22, data23, data31, data32, data33};

  always #5 clk = ~clk;

  function automatic logic [71:0] w9(input int a, b, c, d, e, f, g, h, i);
    return {8'(a), 8'(b), 8'(c), 8'(d), 8'(e), 8'(f), 8'(g), 8'(h), 8'(i)};
  endfunction

  function automatic int clamp0(input int x);
    return (x < 0) ? 0 : x;
  endfunction

  // Window from the frame store with clamped (replicated) borders.
  function automatic logic [71:0] exp_win(input int r, input int c);
    int rr[3];
    int cc[3];
    logic [71:0] w;
    rr[0] = clamp0(r - 2); rr[1] = clamp0(r - 1); rr[2] = r;
    cc[0] = clamp0(c - 2); cc[1] = clamp0(c - 1); cc[2] = c;
    w = 72'h0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w = {w[63:0], img[rr[i]][cc[j]]};
    return w;
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic px(input int v);
    pix_href = 1'b1;
    pix_data = 8'(v);
    if (bcol < H) begin
      img[brow][bcol] = 8'(v);
      exp_q.push_back(exp_win(brow, bcol));
    end else begin
      exp_q.push_back(exp_win(brow, H - 1));
    end
    bcol++;
    cyc();
  endtask

  task automatic end_line();
    pix_href = 1'b0;
    brow = (brow < V - 1) ? brow + 1 : brow;
    bcol = 0;
    cyc();
    cyc();
  endtask

  task automatic vs_pulse();
    pix_href  = 1'b0;
    pix_vsync = 1'b1;
    brow = 0;
    bcol = 0;
    cyc();
    chk("win_vsync_high", win_vsync, 1);
    pix_vsync = 1'b0;
    cyc();
    chk("win_vsync_low", win_vsync, 0);
  endtask

  // Scoreboard monitor: every valid window must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && win_href) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL window_unexpected: got win_href=1 with taps %h, expected no window", taps);
      end else begin
        logic [71:0] e;
        e = exp_q.pop_front();
        if (taps !== e) begin
          errors++;
          $display("FAIL window: got %h expected %h", taps, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++)
        img[r][c] = 8'h00;

    // Reset state.
    repeat (3) cyc();
    chk("rst_taps", taps, 72'h0);
    chk("rst_flags", {win_vsync, win_href, line_len_err}, 3'b000);
    rst_n = 1'b1;
    cyc();

    // Href before any vsync: IDLE ignores pixels.
    for (int i = 0; i < 3; i++) begin
      pix_href = 1'b1;
      pix_data = 8'hAA;
      cyc();
      chk("idle_href", win_href, 0);
    end
    chk("idle_taps", taps, 72'h0);
    pix_href = 1'b0;
    cyc();

    // Frame A: 4x4 raster of 0..15.
    vs_pulse();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        px(r * 4 + c);
        if (r == 0 && c == 0) chk("r0c0", taps, w9(0, 0, 0, 0, 0, 0, 0, 0, 0));
        if (r == 1 && c == 0) chk("r1c0", taps, w9(0, 0, 0, 0, 0, 0, 4, 4, 4));
        if (r == 1 && c == 1) chk("r1c1", taps, w9(0, 0, 1, 0, 0, 1, 4, 4, 5));
        if (r == 2 && c == 3) chk("r2c3", taps, w9(1, 2, 3, 5, 6, 7, 9, 10, 11));
      end
      end_line();
    end
    chk("frameA_err", line_len_err, 0);

    // Frame B: overlong first line, then a normal line.
    vs_pulse();
    px(20); px(21); px(22); px(23);
    chk("long_c3", taps, w9(21, 22, 23, 21, 22, 23, 21, 22, 23));
    chk("long_err_before", line_len_err, 0);
    px(24);
    chk("long_err_5th", line_len_err, 1);
    chk("long_hold_5th", taps, w9(21, 22, 23, 21, 22, 23, 21, 22, 23));
    chk("long_href_5th", win_href, 1);
    px(25);
    chk("long_hold_6th", taps, w9(21, 22, 23, 21, 22, 23, 21, 22, 23));
    end_line();
    chk("long_err_sticky", line_len_err, 1);
    px(30);
    chk("after_long_c0", taps, w9(20, 20, 20, 20, 20, 20, 30, 30, 30));
    px(31); px(32); px(33);
    chk("after_long_c3", taps, w9(21, 22, 23, 21, 22, 23, 31, 32, 33));
    end_line();

    // Frame C: short line.
    vs_pulse();
    chk("vsync_clears_err", line_len_err, 0);
    px(40); px(41); px(42);
    chk("short_err_inline", line_len_err, 0);
    pix_href = 1'b0;
    brow = 1;
    bcol = 0;
    cyc();
    chk("short_err_fall", line_len_err, 1);
    cyc();
    vs_pulse();
    chk("short_err_cleared", line_len_err, 0);

    // Vsync rising edge together with href: pixel dropped, position reset.
    px(50); px(51);
    pix_vsync = 1'b1;
    pix_href  = 1'b1;
    pix_data  = 8'd52;
    brow = 0;
    bcol = 0;
    cyc();
    chk("vs_href_drop", win_href, 0);
    chk("vs_href_hold", taps, w9(50, 50, 51, 50, 50, 51, 50, 50, 51));
    chk("vs_href_wvs", win_vsync, 1);
    pix_vsync = 1'b0;
    px(60);
    chk("vs_href_restart", taps, w9(60, 60, 60, 60, 60, 60, 60, 60, 60));
    px(61);
    end_line();

    // Asynchronous reset in the middle of a line.
    px(70); px(71);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_taps", taps, 72'h0);
    chk("async_rst_flags", {win_vsync, win_href, line_len_err}, 3'b000);
    pix_href = 1'b0;
    @(negedge clk);
    cyc();
    rst_n = 1'b1;
    brow = 0;
    bcol = 0;
    for (int i = 0; i < 3; i++) begin
      pix_href = 1'b1;
      pix_data = 8'h55;
      cyc();
      chk("post_rst_idle", win_href, 0);
    end
    pix_href = 1'b0;
    cyc();
    vs_pulse();
    px(80); px(81); px(82); px(83);
    chk("post_rst_c3", taps, w9(81, 82, 83, 81, 82, 83, 81, 82, 83));
    end_line();

    chk("scoreboard_drained", 72'(exp_q.size()), 72'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
